// File: rtl/result_uart_reporter.sv
// Sends each new value of the core's 8-bit result as an ASCII frame "HH\r\n"
// over an 8N1 UART line (LSB first). Intermediate values seen while busy are dropped.
module result_uart_reporter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] result,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_count
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cfg
    $error("result_uart_reporter: CLKS_PER_BIT must be in 2..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [1:0]  r_byte, w_byte_nxt;
  logic [7:0]  r_shadow, w_shadow_nxt;
  logic [7:0]  r_snap, w_snap_nxt;
  logic [7:0]  r_fcnt, w_fcnt_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_busy, w_busy_nxt;
  logic [7:0]  w_char;
  logic        w_baud_end;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    case (r_byte)
      2'd0:    w_char = hex_ascii(r_snap[7:4]);
      2'd1:    w_char = hex_ascii(r_snap[3:0]);
      2'd2:    w_char = 8'h0D;
      default: w_char = 8'h0A;
    endcase
  end

  assign w_baud_end = (r_baud == BAUD_LAST);

  // tx is registered: each transition loads the level of the next bit period.
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud;
    w_bit_nxt    = r_bit;
    w_byte_nxt   = r_byte;
    w_shadow_nxt = r_shadow;
    w_snap_nxt   = r_snap;
    w_fcnt_nxt   = r_fcnt;
    w_tx_nxt     = r_tx;
    w_busy_nxt   = r_busy;
    case (r_state)
      S_IDLE: begin
        if (result != r_shadow) begin
          w_snap_nxt   = result;
          w_shadow_nxt = result;
          w_state_nxt  = S_START;
          w_tx_nxt     = 1'b0;
          w_busy_nxt   = 1'b1;
          w_baud_nxt   = 16'd0;
          w_bit_nxt    = 3'd0;
          w_byte_nxt   = 2'd0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = 16'd0;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = w_char[0];
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = 16'd0;
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
            w_tx_nxt  = w_char[3'(r_bit + 3'd1)];
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = 16'd0;
          if (r_byte != 2'd3) begin
            w_byte_nxt  = r_byte + 2'd1;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_byte_nxt  = 2'd0;
            w_busy_nxt  = 1'b0;
            w_fcnt_nxt  = r_fcnt + 8'd1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_baud   <= 16'd0;
      r_bit    <= 3'd0;
      r_byte   <= 2'd0;
      r_shadow <= 8'h00;
      r_snap   <= 8'h00;
      r_fcnt   <= 8'h00;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_byte   <= w_byte_nxt;
      r_shadow <= w_shadow_nxt;
      r_snap   <= w_snap_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign tx          = r_tx;
  assign busy        = r_busy;
  assign frame_count = r_fcnt;

endmodule

// File: tb/tb_result_uart_reporter.sv
// Scoreboard bench: stimulus queues expected ASCII bytes, a UART monitor decodes tx
// and pops/compares each received byte; timing and counters are checked directly.
module tb_result_uart_reporter;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] result;
  wire        tx;
  wire        busy;
  wire [7:0]  frame_count;

  always #5 clk = ~clk;

  result_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .result(result),
    .tx(tx), .busy(busy), .frame_count(frame_count)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // busy high-time and low-gap tracker
  int busy_cnt = 0, last_len = 0, idle_cnt = 0, last_gap = 0;
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
      idle_cnt = 0;
    end else if (busy) begin
      if (busy_cnt == 0) last_gap = idle_cnt;
      busy_cnt++;
      idle_cnt = 0;
    end else begin
      if (busy_cnt != 0) last_len = busy_cnt;
      busy_cnt = 0;
      idle_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input string s);
    exp_q.push_back(s[0]);
    exp_q.push_back(s[1]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (busy === lvl) break;
    end
    if (i == 5000) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout waiting busy=%0b, got %0b", name, lvl, busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    result = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // UART monitor: samples mid-bit on negedges; a reset aborts the byte in flight
  initial begin : mon
    logic [7:0] d, e;
    logic st_ok, sp, aborted;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        aborted = 1'b0;
        st_ok   = 1'b1;
        sp      = 1'b0;
        d       = 8'h00;
        for (int c = 1; c <= 9*CPB + CPB/2; c++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (c == CPB/2 && tx !== 1'b0) st_ok = 1'b0;
          for (int b = 0; b < 8; b++)
            if (c == CPB*(1+b) + CPB/2) d[b] = tx;
          if (c == 9*CPB + CPB/2) sp = tx;
        end
        if (!aborted) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL uart_byte: unexpected byte %02h", d);
          end else begin
            e = exp_q.pop_front();
            if (d !== e || !st_ok || sp !== 1'b1) begin
              n_err++;
              $display("FAIL uart_byte: got %02h (start_ok=%0b stop=%0b) expected %02h", d, st_ok, sp, e);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int bad;
    reset  = 1'b1;
    result = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_fc", frame_count, 0);
    reset = 1'b0;

    // 1: no change, no frame
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || frame_count !== 8'd0) bad++;
    end
    check("t1_idle_hold", bad, 0);

    // 2: single frame
    result = 8'h3C;
    push_frame("3C");
    @(negedge clk);
    check("t2_txfall", tx, 0);
    check("t2_busy", busy, 1);
    wait_busy(1'b0, "t2_end");
    @(negedge clk);
    check("t2_len", last_len, 160);
    check("t2_fc", frame_count, 1);
    check("t2_q", exp_q.size(), 0);

    // 3: changes mid-frame, only the latest is sent
    do_reset();
    result = 8'h3C;
    push_frame("3C");
    wait_busy(1'b1, "t3_start");
    repeat (20) @(negedge clk);
    result = 8'h05;
    repeat (40) @(negedge clk);
    result = 8'hA7;
    push_frame("A7");
    wait_busy(1'b0, "t3_end1");
    wait_busy(1'b1, "t3_start2");
    @(negedge clk);
    check("t3_gap", last_gap, 1);
    wait_busy(1'b0, "t3_end2");
    @(negedge clk);
    check("t3_len", last_len, 160);
    check("t3_fc", frame_count, 2);
    check("t3_q", exp_q.size(), 0);

    // 4: excursion returning to shadow
    do_reset();
    result = 8'h3C;
    push_frame("3C");
    wait_busy(1'b1, "t4_s1");
    wait_busy(1'b0, "t4_e1");
    result = 8'h11;
    push_frame("11");
    wait_busy(1'b1, "t4_s2");
    repeat (30) @(negedge clk);
    result = 8'h3C;
    push_frame("3C");
    wait_busy(1'b0, "t4_e2");
    wait_busy(1'b1, "t4_s3");
    @(negedge clk);
    check("t4_gap", last_gap, 1);
    repeat (20) @(negedge clk);
    result = 8'h11;
    repeat (20) @(negedge clk);
    result = 8'h3C;
    wait_busy(1'b0, "t4_e3");
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("t4_quiet", bad, 0);
    check("t4_fc", frame_count, 3);

    // 5: reset during data bit 5 of byte1
    result = 8'h5A;
    exp_q.push_back(8'h35);
    wait_busy(1'b1, "t5_start");
    repeat (65) @(negedge clk);
    check("t5_pre_busy", busy, 1);
    check("t5_pre_tx", tx, 0);
    check("t5_pre_fc", frame_count, 3);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_tx", tx, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_fc", frame_count, 0);
    repeat (3) @(negedge clk);
    result = 8'h3C;
    push_frame("3C");
    reset = 1'b0;
    wait_busy(1'b1, "t5_s2");
    wait_busy(1'b0, "t5_e2");
    @(negedge clk);
    check("t5_len", last_len, 160);
    check("t5_fc", frame_count, 1);
    check("t5_q", exp_q.size(), 0);

    // 6: 256 frames, counter wraps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        result = 8'hFF;
        push_frame("FF");
      end else if (i % 2 == 1) begin
        result = 8'hAA;
        push_frame("AA");
      end else begin
        result = 8'h55;
        push_frame("55");
      end
      wait_busy(1'b1, "t6_start");
      wait_busy(1'b0, "t6_end");
      if (i == 254) check("t6_fc255", frame_count, 255);
    end
    @(negedge clk);
    check("t6_fc_wrap", frame_count, 0);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check("final_q_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_uart_reporter.md
Name: result_uart_reporter

Overview:
- Downstream consumer of the CPU core's 8-bit `result` output (data memory word 0).
- Whenever `result` changes, it transmits the new value on a UART line as a 4-byte ASCII frame: two uppercase hex digits, then CR, then LF.
- Format is 8N1, LSB first.
- Gives the bench and the board a human-readable trace of program output without probing internal memory.

Parameters:
- CLKS_PER_BIT, default 16: clk cycles per UART bit. Legal range is 2..65535; values outside it are a configuration error.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- result, input, 8: value from the CPU core; sampled every clk edge while idle.
- tx, output, 1: UART serial output; idle level is high.
- busy, output, 1: high while a frame is in progress.
- frame_count, output, 8: number of frames completed; wraps modulo 256.

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-frame):
- tx=1, busy=0, frame_count=0.
- shadow register = 8'h00, state = IDLE, all bit/byte/baud counters = 0.
- No partial frame resumes after reset.
- Since the core resets its result to 0, no frame is sent until the value first changes.

Internal state:
- shadow[7:0] holds the last value accepted for transmission.
- snap[7:0] holds the value being sent.

States:
- IDLE: tx=1, busy=0. On any edge where result != shadow:
  - snap<=result, shadow<=result;
  - enter START for byte 0; tx<=0, busy<=1 on that same edge.
  - If result == shadow, stay in IDLE.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; bit index 0..7. After bit 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. Then:
  - if byte index < 3: increment the byte index and go to START;
  - else: go to IDLE, busy<=0, frame_count<=frame_count+1 on that edge.

Byte sequence:
- byte0 = ASCII of snap[7:4]; byte1 = ASCII of snap[3:0].
- Nibble mapping: 0-9 to 8'h30-8'h39, A-F to 8'h41-8'h46.
- byte2 = 8'h0D, byte3 = 8'h0A.

Timing:
- Exact frame length: 40*CLKS_PER_BIT cycles from the tx falling edge to busy falling.
- No inter-byte gap beyond the stop bit.
- At least one IDLE cycle (tx=1, busy=0) separates consecutive frames. The comparison is made in that IDLE cycle, so the earliest next start is one cycle after busy falls.

Result changes during a frame:
- result is ignored while busy; snap does not change mid-frame.
- Intermediate values are dropped. On return to IDLE, the current result is compared with shadow:
  - if they differ, exactly one new frame carries the latest value;
  - if result has returned to the shadow value, no frame is sent.

Counters:
- Baud counter: 16 bits, counts 0..CLKS_PER_BIT-1.
- frame_count: 255+1 wraps to 0.

No handshake input. The block never back-pressures the core; loss of intermediate values is by design.

Test Plan:
1. Reset, then hold result=8'h00 for 2000 cycles -> tx=1, busy=0, frame_count=0 throughout.
2. CLKS_PER_BIT=4; result 8'h00->8'h3C:
   - tx falls on the first edge after the change;
   - decoded bytes are 8'h33, 8'h43, 8'h0D, 8'h0A;
   - busy is high for exactly 160 cycles; frame_count=1.
3. CLKS_PER_BIT=4; result 8'h3C, then 8'h05 at cycle 20, then 8'hA7 at cycle 60 of the frame:
   - first frame reads "3C\r\n";
   - busy is low for exactly 1 cycle;
   - second frame reads "A7\r\n";
   - 8'h05 is never sent; frame_count=2.
4. After "3C" is sent, result goes 8'h3C->8'h11->8'h3C, with the whole excursion inside a second frame's busy window triggered by 8'h11 -> frames "11", then "3C"; sequence 8'h11->8'h3C within one idle-free window sends only the latest value.
5. Assert reset during data bit 5 of byte1 -> same edge/asynchronously tx=1, busy=0, frame_count=0. Release with result=8'h3C -> a complete fresh frame "3C\r\n" starting from byte0.
6. Drive 256 alternating values ending at 8'hFF -> frame_count wraps to 0 after the 256th frame; last frame decodes as 8'h46, 8'h46, 8'h0D, 8'h0A.
